// File: rtl/rect_fill_generator_if.sv
// Handshake bundle between the command fifo, the rectangle-fill generator and the pixel-write stage.
// The master view is the generator: it consumes fifo bytes and produces pixel writes.
interface rect_fill_generator_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_rts;
  logic                  in_rtr;
  logic [DATA_WIDTH-1:0] out_x;
  logic [DATA_WIDTH-1:0] out_y;
  logic [DATA_WIDTH-1:0] out_color;
  logic                  out_rts;
  logic                  out_rtr;

  modport master (
    input  in_data, in_rts, out_rtr,
    output in_rtr, out_x, out_y, out_color, out_rts
  );

  modport slave (
    output in_data, in_rts, out_rtr,
    input  in_rtr, out_x, out_y, out_color, out_rts
  );
endinterface

// File: rtl/rect_fill_generator.sv
// Rectangle-fill generator: collects a 5-byte command (X0, Y0, X1, Y1, COLOR) from the
// command fifo, clips the rectangle to the screen and emits one pixel write per covered
// coordinate in raster order (x fastest), one per cycle when the pixel stage never stalls.
module rect_fill_generator #(
  parameter int DATA_WIDTH = 8,
  parameter int SCREEN_W   = 160,
  parameter int SCREEN_H   = 120
) (
  input  logic                  clk,
  input  logic                  rst_,
  rect_fill_generator_if.master bus,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    SETUP = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [DATA_WIDTH-1:0] X_LIM = DATA_WIDTH'(SCREEN_W - 1);
  localparam logic [DATA_WIDTH-1:0] Y_LIM = DATA_WIDTH'(SCREEN_H - 1);
  localparam logic [DATA_WIDTH-1:0] ONE   = DATA_WIDTH'(1);

  state_t                state, state_n;
  logic [2:0]            cnt, cnt_n;
  logic [DATA_WIDTH-1:0] arg   [5];
  logic [DATA_WIDTH-1:0] arg_n [5];
  logic [DATA_WIDTH-1:0] xmin, xmin_n, xmax, xmax_n;
  logic [DATA_WIDTH-1:0] ymin, ymin_n, ymax, ymax_n;
  logic [DATA_WIDTH-1:0] x_q, x_n, y_q, y_n, color_q, color_n;
  logic                  rts_q, rts_n;

  logic [DATA_WIDTH-1:0] x_lo, x_hi, y_lo, y_hi;

  // Corners may arrive in either order, so sort each axis before clipping.
  assign x_lo = (arg[0] < arg[2]) ? arg[0] : arg[2];
  assign x_hi = (arg[0] < arg[2]) ? arg[2] : arg[0];
  assign y_lo = (arg[1] < arg[3]) ? arg[1] : arg[3];
  assign y_hi = (arg[1] < arg[3]) ? arg[3] : arg[1];

  // All handshake and status outputs come straight from registers.
  assign bus.in_rtr    = (state == FETCH);
  assign bus.out_rts   = rts_q;
  assign bus.out_x     = x_q;
  assign bus.out_y     = y_q;
  assign bus.out_color = color_q;
  assign busy          = (state != FETCH);
  assign done          = (state == DONE);

  // Next-state and next-datapath logic; every register holds unless its state updates it.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    arg_n   = arg;
    xmin_n  = xmin;
    xmax_n  = xmax;
    ymin_n  = ymin;
    ymax_n  = ymax;
    x_n     = x_q;
    y_n     = y_q;
    color_n = color_q;
    rts_n   = rts_q;
    case (state)
      FETCH: begin
        if (bus.in_rts) begin
          if (cnt <= 3'd4) begin
            arg_n[cnt] = bus.in_data;
          end
          if (cnt == 3'd4) begin
            cnt_n   = 3'd0;
            state_n = SETUP;
          end else begin
            cnt_n = cnt + 3'd1;
          end
        end
      end
      SETUP: begin
        xmin_n = x_lo;
        xmax_n = (x_hi > X_LIM) ? X_LIM : x_hi;
        ymin_n = y_lo;
        ymax_n = (y_hi > Y_LIM) ? Y_LIM : y_hi;
        if ((x_lo > X_LIM) || (y_lo > Y_LIM)) begin
          state_n = DONE;
        end else begin
          state_n = DRAW;
          x_n     = x_lo;
          y_n     = y_lo;
          color_n = arg[4];
          rts_n   = 1'b1;
        end
      end
      DRAW: begin
        if (bus.out_rtr) begin
          if (x_q < xmax) begin
            x_n = x_q + ONE;
          end else if (y_q < ymax) begin
            x_n = xmin;
            y_n = y_q + ONE;
          end else begin
            rts_n   = 1'b0;
            state_n = DONE;
          end
        end
      end
      DONE: begin
        state_n = FETCH;
      end
      default: begin
        state_n = FETCH;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial command and any pixel in flight.
  always_ff @(posedge clk) begin
    if (rst_) begin
      state   <= FETCH;
      cnt     <= 3'd0;
      arg     <= '{default: '0};
      xmin    <= '0;
      xmax    <= '0;
      ymin    <= '0;
      ymax    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      color_q <= '0;
      rts_q   <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      arg     <= arg_n;
      xmin    <= xmin_n;
      xmax    <= xmax_n;
      ymin    <= ymin_n;
      ymax    <= ymax_n;
      x_q     <= x_n;
      y_q     <= y_n;
      color_q <= color_n;
      rts_q   <= rts_n;
    end
  end

endmodule

// File: tb/tb_rect_fill_generator.sv
// Self-checking bench for rect_fill_generator: a reference model pushes the expected pixel
// stream into a queue as each command is fed, and a monitor pops and compares every pixel
// the generator hands to the pixel stage.
module tb_rect_fill_generator;

  localparam int DW = 8;
  localparam int SW = 160;
  localparam int SH = 120;

  logic clk = 1'b0;
  logic rst_;
  logic busy;
  logic done;

  int checks   = 0;
  int failures = 0;

  logic [23:0] exp_q[$];
  int          rtr_mode = 0;
  int          pat_idx  = 0;

  logic        stall_prev = 1'b0;
  logic [23:0] held       = '0;

  rect_fill_generator_if #(.DATA_WIDTH(DW)) bus ();

  rect_fill_generator #(
    .DATA_WIDTH(DW),
    .SCREEN_W  (SW),
    .SCREEN_H  (SH)
  ) dut (
    .clk (clk),
    .rst_(rst_),
    .bus (bus),
    .busy(busy),
    .done(done)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Offer one byte to the generator and hold it until it is accepted.
  task automatic sendByte(input logic [7:0] b, input int gap);
    int n;
    for (int g = 0; g < gap; g++) begin
      @(posedge clk);
      #1;
    end
    bus.in_data = b;
    bus.in_rts  = 1'b1;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (bus.in_rtr === 1'b1) break;
      n++;
      if (n >= 2000) begin
        checkOutput("in_rtr_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_rts = 1'b0;
  endtask

  // Push the expected pixels of a command into the scoreboard, then feed its five bytes.
  task automatic applyStimulus(input logic [7:0] x0, input logic [7:0] y0, input logic [7:0] x1,
                               input logic [7:0] y1, input logic [7:0] c, input int gap);
    int xa, xb, ya, yb;
    xa = (x0 < x1) ? int'(x0) : int'(x1);
    xb = (x0 < x1) ? int'(x1) : int'(x0);
    ya = (y0 < y1) ? int'(y0) : int'(y1);
    yb = (y0 < y1) ? int'(y1) : int'(y0);
    if (xb > SW - 1) xb = SW - 1;
    if (yb > SH - 1) yb = SH - 1;
    if (!((xa > SW - 1) || (ya > SH - 1))) begin
      for (int y = ya; y <= yb; y++) begin
        for (int x = xa; x <= xb; x++) begin
          exp_q.push_back({8'(x), 8'(y), c});
        end
      end
    end
    sendByte(x0, gap);
    sendByte(y0, gap);
    sendByte(x1, gap);
    sendByte(y1, gap);
    sendByte(c, gap);
  endtask

  // Wait (bounded) for the done pulse and confirm every expected pixel was seen.
  task automatic waitDone(input string tag, input int budget);
    int n;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (done === 1'b1) break;
      n++;
      if (n >= budget) begin
        checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    checkOutput({tag, "_drained"}, exp_q.size(), 32'd0);
  endtask

  // Pixel monitor: scores each accepted pixel and checks outputs hold steady across stalls.
  always @(negedge clk) begin
    if (rst_ !== 1'b0) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checkOutput("stall_rts", bus.out_rts, 32'd1);
        checkOutput("stall_hold", {bus.out_x, bus.out_y, bus.out_color}, held);
      end
      if (bus.out_rts === 1'b1) begin
        checkOutput("in_rtr_during_draw", bus.in_rtr, 32'd0);
      end
      if (bus.out_rts === 1'b1 && bus.out_rtr === 1'b1) begin
        if (exp_q.size() == 0) begin
          checkOutput("extra_pixel", {bus.out_x, bus.out_y, bus.out_color}, 32'hFFFF_FFFF);
        end else begin
          checkOutput("pixel", {bus.out_x, bus.out_y, bus.out_color}, exp_q.pop_front());
        end
      end
      stall_prev = (bus.out_rts === 1'b1) && (bus.out_rtr === 1'b0);
      held       = {bus.out_x, bus.out_y, bus.out_color};
    end
  end

  initial begin
    int n;
    rst_        = 1'b1;
    bus.in_data = '0;
    bus.in_rts  = 1'b0;
    bus.out_rtr = 1'b1;

    // Pixel-stage acceptance pattern: 0 always ready, 1 repeating 1,0,0, 2 random.
    fork
      forever begin
        @(posedge clk);
        #1;
        case (rtr_mode)
          0: bus.out_rtr = 1'b1;
          1: begin
            bus.out_rtr = (pat_idx == 0);
            pat_idx     = (pat_idx + 1) % 3;
          end
          default: bus.out_rtr = 1'($urandom_range(0, 1));
        endcase
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    rst_ = 1'b0;
    $display("[TB] reset state");
    checkOutput("rst_in_rtr", bus.in_rtr, 32'd1);
    checkOutput("rst_out_rts", bus.out_rts, 32'd0);
    checkOutput("rst_out_xyc", {bus.out_x, bus.out_y, bus.out_color}, 32'd0);
    checkOutput("rst_busy", busy, 32'd0);
    checkOutput("rst_done", done, 32'd0);

    $display("[TB] basic 2x2 fill with exact timing");
    rtr_mode = 0;
    applyStimulus(8'd10, 8'd20, 8'd11, 8'd21, 8'h3F, 0);
    @(negedge clk);
    checkOutput("t1_setup_rts", bus.out_rts, 32'd0);
    checkOutput("t1_setup_busy", busy, 32'd1);
    checkOutput("t1_setup_in_rtr", bus.in_rtr, 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("t1_pixel_rts", bus.out_rts, 32'd1);
      checkOutput("t1_pixel_xy", {bus.out_x, bus.out_y}, {8'(10 + k % 2), 8'(20 + k / 2)});
    end
    @(negedge clk);
    checkOutput("t1_done", done, 32'd1);
    checkOutput("t1_done_rts", bus.out_rts, 32'd0);
    @(negedge clk);
    checkOutput("t1_done_pulse", done, 32'd0);
    checkOutput("t1_in_rtr", bus.in_rtr, 32'd1);
    checkOutput("t1_busy", busy, 32'd0);
    checkOutput("t1_drained", exp_q.size(), 32'd0);
    @(posedge clk);
    #1;

    $display("[TB] reversed corners");
    applyStimulus(8'd5, 8'd7, 8'd2, 8'd3, 8'hAA, 0);
    waitDone("t2", 100);

    $display("[TB] clipping at screen edge");
    applyStimulus(8'd150, 8'd110, 8'd200, 8'd130, 8'h01, 0);
    waitDone("t3", 400);

    $display("[TB] fully off-screen command");
    applyStimulus(8'd170, 8'd0, 8'd180, 8'd5, 8'h55, 0);
    @(negedge clk);
    checkOutput("t3e_setup_done", done, 32'd0);
    checkOutput("t3e_setup_busy", busy, 32'd1);
    @(negedge clk);
    checkOutput("t3e_done", done, 32'd1);
    checkOutput("t3e_no_pixel", bus.out_rts, 32'd0);
    @(negedge clk);
    checkOutput("t3e_in_rtr", bus.in_rtr, 32'd1);
    @(posedge clk);
    #1;

    $display("[TB] stalling pixel stage");
    rtr_mode = 1;
    pat_idx  = 0;
    applyStimulus(8'd10, 8'd20, 8'd11, 8'd21, 8'h3F, 0);
    waitDone("t4", 100);

    $display("[TB] fifo gaps and random stalls, back-to-back commands");
    rtr_mode = 2;
    applyStimulus(8'd10, 8'd20, 8'd11, 8'd21, 8'h3F, 3);
    applyStimulus(8'd6, 8'd4, 8'd3, 8'd5, 8'h12, 2);
    waitDone("t5", 300);
    applyStimulus(8'd9, 8'd9, 8'd9, 8'd9, 8'hC3, 1);
    waitDone("t5_single", 100);

    $display("[TB] reset after partial command");
    rtr_mode = 0;
    sendByte(8'd40, 0);
    sendByte(8'd50, 0);
    sendByte(8'd45, 0);
    rst_ = 1'b1;
    @(posedge clk);
    #1;
    rst_ = 1'b0;
    checkOutput("t6a_out_rts", bus.out_rts, 32'd0);
    checkOutput("t6a_busy", busy, 32'd0);
    checkOutput("t6a_in_rtr", bus.in_rtr, 32'd1);
    applyStimulus(8'd1, 8'd2, 8'd2, 8'd3, 8'h77, 0);
    waitDone("t6a", 100);

    $display("[TB] reset mid-draw");
    applyStimulus(8'd0, 8'd0, 8'd9, 8'd9, 8'h44, 0);
    n = 0;
    while (exp_q.size() >= 60) begin
      @(negedge clk);
      n++;
      if (n >= 500) begin
        checkOutput("t6b_draw_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    rst_ = 1'b1;
    @(posedge clk);
    #1;
    rst_ = 1'b0;
    exp_q.delete();
    checkOutput("t6b_out_rts", bus.out_rts, 32'd0);
    checkOutput("t6b_busy", busy, 32'd0);
    checkOutput("t6b_in_rtr", bus.in_rtr, 32'd1);
    applyStimulus(8'd5, 8'd5, 8'd7, 8'd6, 8'h99, 0);
    waitDone("t6b", 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
